// File: rtl/rtc_sched_if.sv
// rtc_sched_if: set-time write request channel into rtc_sched.
// Requester holds wr_req until wr_ack; wr_reg/wr_data are sampled on acceptance.
interface rtc_sched_if;
   logic       wr_req;
   logic [1:0] wr_reg;
   logic [7:0] wr_data;
   logic       wr_ack;

   modport master (
      output wr_req,
      output wr_reg,
      output wr_data,
      input  wr_ack
   );

   modport slave (
      input  wr_req,
      input  wr_reg,
      input  wr_data,
      output wr_ack
   );
endinterface

// File: rtl/rtc_sched.sv
// rtc_sched: DS1302-style 3-wire RTC sequencer (poll sec/min/hour, set-time writes).
// Define RTC_WP_EN to wrap every write in write-protect clear/set transactions.
module rtc_sched #(
   parameter int CLK_DIV = 4
) (
   input  logic        sclk,
   input  logic        rst_n,
   input  logic        poll_tick,
   rtc_sched_if.slave  wr,
   output logic [7:0]  sec,
   output logic [7:0]  min,
   output logic [7:0]  hour,
   output logic        valid,
   output logic        busy,
   output logic        ce,
   output logic        ser_clk,
   output logic        io_out,
   output logic        io_oe,
   input  logic        io_in
);

   localparam int CW = $clog2(2 * CLK_DIV);

`ifdef RTC_WP_EN
   localparam logic [1:0] WR_LAST = 2'd2;
`else
   localparam logic [1:0] WR_LAST = 2'd0;
`endif

   typedef enum logic [2:0] {
      IDLE,
      CE_SETUP,
      CMD,
      DATA,
      CE_HOLD,
      GAP
   } state_t;

   state_t        state_q;
   state_t        state_d;

   logic [CW-1:0] cnt_q;
   logic          half_q;
   logic [2:0]    bit_q;
   logic [1:0]    step_q;
   logic          mode_wr_q;
   logic [1:0]    reg_q;
   logic [7:0]    wdat_q;
   logic [6:0]    rx_q;
   logic [7:0]    sh_sec;
   logic [7:0]    sh_min;
   logic [7:0]    sh_hour;
   logic          pend_q;
   logic          ack_q;
   logic          valid_q;

   logic [CW-1:0] lim;
   logic          cnt_end;
   logic          byte_end;
   logic [1:0]    last_step;
   logic          take_wr;
   logic          take_poll;
   logic          seq_done;
   logic          rx_sample;
   logic [7:0]    cmd;
   logic [7:0]    txd;
   logic [7:0]    rx_byte;

   // GAP lasts a full bit period; every other timed phase is one half-bit
   always_comb begin
      lim       = (state_q == GAP) ? CW'(2 * CLK_DIV - 1)
                                   : CW'(CLK_DIV - 1);
      cnt_end   = (cnt_q == lim);
      byte_end  = cnt_end && half_q && (bit_q == 3'd7);
      last_step = mode_wr_q ? WR_LAST : 2'd2;
      rx_sample = (state_q == DATA) && !mode_wr_q
                  && !half_q && cnt_end;
      rx_byte   = {io_in, rx_q};
   end

   always_comb begin
      cmd = {5'b10000, step_q, 1'b1};
      txd = 8'h00;
      if (mode_wr_q) begin
         cmd = {5'b10000, reg_q, 1'b0};
         txd = wdat_q;
`ifdef RTC_WP_EN
         if (step_q != 2'd1) begin
            cmd = 8'h8E;
            txd = (step_q == 2'd0) ? 8'h00 : 8'h80;
         end
`endif
      end
   end

   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      take_wr   = 1'b0;
      take_poll = 1'b0;
      seq_done  = 1'b0;
      ce        = 1'b0;
      ser_clk   = 1'b0;
      io_oe     = 1'b0;
      io_out    = 1'b0;
      unique case (state_q)
         IDLE: begin
            // ack/valid cycles are dead time so a held wr_req is not re-taken
            if (!ack_q && !valid_q) begin
               if (wr.wr_req) begin
                  take_wr = 1'b1;
                  if (wr.wr_reg != 2'd3) state_d = CE_SETUP;
               end else if (pend_q) begin
                  take_poll = 1'b1;
                  state_d   = CE_SETUP;
               end
            end
         end
         CE_SETUP: begin
            ce = 1'b1;
            if (cnt_end) state_d = CMD;
         end
         CMD: begin
            ce      = 1'b1;
            ser_clk = half_q;
            io_oe   = 1'b1;
            io_out  = cmd[bit_q];
            if (byte_end) state_d = DATA;
         end
         DATA: begin
            ce      = 1'b1;
            ser_clk = half_q;
            io_oe   = mode_wr_q;
            io_out  = mode_wr_q & txd[bit_q];
            if (byte_end) state_d = CE_HOLD;
         end
         CE_HOLD: begin
            ce = 1'b1;
            if (cnt_end) state_d = GAP;
         end
         GAP: begin
            if (cnt_end) begin
               if (step_q == last_step) begin
                  state_d  = IDLE;
                  seq_done = 1'b1;
               end else begin
                  state_d = CE_SETUP;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      busy = (state_q != IDLE) | ack_q | valid_q
             | take_wr | take_poll;
   end

   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         half_q    <= 1'b0;
         bit_q     <= 3'd0;
         step_q    <= 2'd0;
         mode_wr_q <= 1'b0;
         reg_q     <= 2'd0;
         wdat_q    <= 8'h00;
         rx_q      <= 7'h00;
         sh_sec    <= 8'h00;
         sh_min    <= 8'h00;
         sh_hour   <= 8'h00;
         sec       <= 8'h00;
         min       <= 8'h00;
         hour      <= 8'h00;
         pend_q    <= 1'b0;
         ack_q     <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         ack_q   <= 1'b0;
         valid_q <= 1'b0;
         pend_q  <= take_poll ? 1'b0 : (pend_q | poll_tick);

         if (take_wr) begin
            mode_wr_q <= 1'b1;
            reg_q     <= wr.wr_reg;
            wdat_q    <= wr.wr_data;
            step_q    <= 2'd0;
            ack_q     <= (wr.wr_reg == 2'd3);
         end
         if (take_poll) begin
            mode_wr_q <= 1'b0;
            step_q    <= 2'd0;
         end

         if (state_q == IDLE || cnt_end) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end

         if ((state_q == CMD || state_q == DATA) && cnt_end) begin
            half_q <= ~half_q;
            if (half_q) bit_q <= bit_q + 3'd1;
         end

         if (rx_sample) begin
            rx_q <= rx_byte[7:1];
            if (bit_q == 3'd7) begin
               unique case (step_q)
                  2'd0:    sh_sec  <= rx_byte;
                  2'd1:    sh_min  <= rx_byte;
                  default: sh_hour <= rx_byte;
               endcase
            end
         end

         if (state_q == GAP && cnt_end && step_q != last_step) begin
            step_q <= step_q + 2'd1;
         end

         if (seq_done) begin
            if (mode_wr_q) begin
               ack_q <= 1'b1;
            end else begin
               sec     <= sh_sec;
               min     <= sh_min;
               hour    <= sh_hour;
               valid_q <= 1'b1;
            end
         end
      end
   end

   assign valid     = valid_q;
   assign wr.wr_ack = ack_q;

endmodule

// File: tb/tb_rtc_sched.sv
// tb_rtc_sched: scoreboard bench for rtc_sched against a behavioural 3-wire RTC.
// Stimulus queues expected bus bytes, time updates and acks; a monitor pops and checks.
module tb_rtc_sched;

   localparam int D = 4;
`ifdef RTC_WP_EN
   localparam int WLAT = 108 * D + 1;
`else
   localparam int WLAT = 36 * D + 1;
`endif
   localparam int PLAT = 108 * D + 2;

   typedef struct {
      int issue;
      int lat;
   } ack_t;

   typedef struct {
      logic [23:0] t;
      int          issue;
      int          lat;
   } tim_t;

   logic       sclk      = 1'b0;
   logic       rst_n     = 1'b0;
   logic       poll_tick = 1'b0;
   logic       io_in     = 1'b0;
   logic [7:0] sec;
   logic [7:0] min;
   logic [7:0] hour;
   logic       valid;
   logic       busy;
   logic       ce;
   logic       ser_clk;
   logic       io_out;
   logic       io_oe;

   rtc_sched_if wr ();

   rtc_sched #(.CLK_DIV(D)) dut (
      .sclk      (sclk),
      .rst_n     (rst_n),
      .poll_tick (poll_tick),
      .wr        (wr.slave),
      .sec       (sec),
      .min       (min),
      .hour      (hour),
      .valid     (valid),
      .busy      (busy),
      .ce        (ce),
      .ser_clk   (ser_clk),
      .io_out    (io_out),
      .io_oe     (io_oe),
      .io_in     (io_in)
   );

   always #5 sclk = ~sclk;

   int cyc = 0;
   always @(posedge sclk) cyc <= cyc + 1;

   logic [15:0] exp_bus [$];
   tim_t        exp_tim [$];
   ack_t        exp_ack [$];

   int n_tests  = 0;
   int n_fail   = 0;
   int timeouts = 0;
   bit done     = 1'b0;
   bit fin      = 1'b0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_unexp(input string name, input logic [31:0] act);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got %0h expected nothing", name, act);
   endtask

   // behavioural RTC plus scoreboard monitor
   logic [7:0]  rtc_regs [3] = '{8'h59, 8'h34, 8'h12};
   int          bits   = 0;
   int          hi_len = 0;
   int          gap    = 0;
   bit          seen_fall = 1'b0;
   bit          ce_p   = 1'b0;
   bit          sck_p  = 1'b0;
   logic [7:0]  mcmd   = 8'h00;
   logic [7:0]  mdat   = 8'h00;
   logic [1:0]  idx;
   logic [23:0] t_p    = 24'h0;
   tim_t        te;
   ack_t        ae;

   always begin
      @(negedge sclk);
      if (done) begin
         if (!fin) begin
            chk("bus_left", exp_bus.size(), 0);
            chk("time_left", exp_tim.size(), 0);
            chk("ack_left", exp_ack.size(), 0);
            chk("timeouts", timeouts, 0);
            fin = 1'b1;
         end
      end else if (!rst_n) begin
         chk("rst_ce", ce, 0);
         chk("rst_sclk", ser_clk, 0);
         chk("rst_oe", io_oe, 0);
         chk("rst_time", {sec, min, hour}, 0);
         chk("rst_flags", {valid, wr.wr_ack, busy}, 0);
         bits = 0; hi_len = 0; gap = 0; seen_fall = 1'b0;
         t_p = 24'h0; io_in = 1'b0; ce_p = 1'b0; sck_p = 1'b0;
      end else begin
         if (valid) begin
            if (exp_tim.size() == 0) begin
               fail_unexp("valid_unexp", {sec, min, hour});
            end else begin
               te = exp_tim.pop_front();
               chk("time", {sec, min, hour}, te.t);
               if (te.lat >= 0) chk("valid_lat", cyc - te.issue, te.lat);
            end
         end else if ({sec, min, hour} !== t_p) begin
            chk("time_early", {sec, min, hour}, t_p);
         end
         t_p = {sec, min, hour};

         if (wr.wr_ack) begin
            if (exp_ack.size() == 0) begin
               fail_unexp("ack_unexp", cyc);
            end else begin
               ae = exp_ack.pop_front();
               if (ae.lat >= 0) chk("ack_lat", cyc - ae.issue, ae.lat);
            end
         end

         if (ce && !ce_p) begin
            if (seen_fall) chk("gap_min", gap >= 2 * D, 1);
            chk("busy_ce", busy, 1);
            bits = 0; hi_len = 0; mcmd = 8'h00; mdat = 8'h00;
         end
         if (ce) hi_len++;

         if (ce && ser_clk && !sck_p) begin
            if (bits < 8) begin
               if (!io_oe) chk("oe_cmd", io_oe, 1);
               mcmd[bits] = io_out;
               if (bits == 7 && mcmd[0]) begin
                  idx  = mcmd[2:1];
                  mdat = (idx != 2'd3) ? rtc_regs[idx] : 8'h00;
               end
            end else if (bits < 16) begin
               if (mcmd[0]) begin
                  if (io_oe) chk("oe_rd", io_oe, 0);
               end else begin
                  if (!io_oe) chk("oe_wr", io_oe, 1);
                  mdat[bits-8] = io_out;
               end
            end
            bits++;
         end

         if (ce && !ser_clk && sck_p && mcmd[0] && bits >= 8 && bits < 16)
            io_in = mdat[bits-8];

         if (!ce && ce_p) begin
            chk("ce_len", hi_len, 34 * D);
            chk("bit_cnt", bits, 16);
            if (exp_bus.size() == 0) fail_unexp("bus_unexp", {mcmd, mdat});
            else chk("bus", {mcmd, mdat}, exp_bus.pop_front());
            if (!mcmd[0] && mcmd[7:3] == 5'b10000 && mcmd[2:1] != 2'd3)
               rtc_regs[mcmd[2:1]] = mdat;
            seen_fall = 1'b1;
            gap = 0;
         end
         if (!ce) gap++;
         ce_p  = ce;
         sck_p = ser_clk;
      end
   end

   task automatic push_poll(input logic [7:0] s, input logic [7:0] m,
                            input logic [7:0] h, input int lat);
      exp_bus.push_back({8'h81, s});
      exp_bus.push_back({8'h83, m});
      exp_bus.push_back({8'h85, h});
      exp_tim.push_back('{{s, m, h}, cyc, lat});
   endtask

   task automatic push_write(input logic [7:0] c, input logic [7:0] d,
                             input int lat);
`ifdef RTC_WP_EN
      exp_bus.push_back(16'h8E00);
      exp_bus.push_back({c, d});
      exp_bus.push_back(16'h8E80);
`else
      exp_bus.push_back({c, d});
`endif
      exp_ack.push_back('{cyc, lat});
   endtask

   task automatic wr_start(input logic [1:0] r, input logic [7:0] d);
      wr.wr_req  = 1'b1;
      wr.wr_reg  = r;
      wr.wr_data = d;
   endtask

   task automatic wr_finish(input int limit);
      int n = 0;
      while (!wr.wr_ack && n < limit) begin
         @(negedge sclk);
         n++;
      end
      if (!wr.wr_ack) timeouts++;
      wr.wr_req = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      repeat (3) @(negedge sclk);
      while (busy && n < limit) begin
         @(negedge sclk);
         n++;
      end
      if (busy) timeouts++;
   endtask

   task automatic tick;
      poll_tick = 1'b1;
      @(negedge sclk);
      poll_tick = 1'b0;
   endtask

   initial begin
      int n;
      wr.wr_req  = 1'b0;
      wr.wr_reg  = 2'd0;
      wr.wr_data = 8'h00;
      repeat (3) @(negedge sclk);
      #1 rst_n = 1'b1;

      // first poll: 59:34:12
      @(negedge sclk);
      push_poll(8'h59, 8'h34, 8'h12, PLAT);
      tick();
      wait_idle(2000);

      // write minutes, then poll to read it back
      @(negedge sclk);
      push_write(8'h82, 8'h45, WLAT);
      wr_start(2'd1, 8'h45);
      wr_finish(1000);
      wait_idle(2000);
      @(negedge sclk);
      push_poll(8'h59, 8'h45, 8'h12, PLAT);
      tick();
      wait_idle(2000);

      // write and tick together: write wins, extra ticks collapse
      @(negedge sclk);
      push_write(8'h84, 8'h08, WLAT);
      push_poll(8'h59, 8'h45, 8'h08, -1);
      wr_start(2'd2, 8'h08);
      tick();
      repeat (20) @(negedge sclk);
      tick();
      repeat (20) @(negedge sclk);
      tick();
      wr_finish(1000);
      wait_idle(2000);
      repeat (200) @(negedge sclk);

      // write arriving mid-poll waits for the poll
      @(negedge sclk);
      push_poll(8'h59, 8'h45, 8'h08, PLAT);
      tick();
      repeat (100) @(negedge sclk);
      push_write(8'h80, 8'h30, -1);
      wr_start(2'd0, 8'h30);
      wr_finish(2000);
      wait_idle(2000);

      // invalid register: immediate ack, no bus traffic
      @(negedge sclk);
      exp_ack.push_back('{cyc, 1});
      wr_start(2'd3, 8'h77);
      wr_finish(10);
      repeat (20) @(negedge sclk);

      // seconds write then read back
      @(negedge sclk);
      push_write(8'h80, 8'h11, WLAT);
      wr_start(2'd0, 8'h11);
      wr_finish(1000);
      wait_idle(2000);
      @(negedge sclk);
      push_poll(8'h11, 8'h45, 8'h08, PLAT);
      tick();
      wait_idle(2000);

      // reset in the middle of a command byte
      @(negedge sclk);
      tick();
      n = 0;
      while (!ce && n < 50) begin
         @(negedge sclk);
         n++;
      end
      if (!ce) timeouts++;
      repeat (8) @(negedge sclk);
      @(posedge sclk);
      #1 rst_n = 1'b0;
      repeat (3) @(negedge sclk);
      #1 rst_n = 1'b1;
      repeat (600) @(negedge sclk);

      @(negedge sclk);
      #1 done = 1'b1;
      @(negedge sclk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
